spi_sample_master: RTL

SPI master (initiator) that serialises parallel sample words onto ss/sclk/mosi, and is the transmitting end for the DFT_SPI sample receiver. Words are pushed through a valid/ready port into a small FIFO and shifted out in SPI mode 0, MSB first. Queued words go back-to-back under a single ss-low window. MISO is captured in full duplex and returned as parallel words, so the same block also drives loopback and readback.

---
 rtl/spi_sample_master.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/spi_sample_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_sample_master
// Description : SPI mode-0 master with a small transmit FIFO. Words are shifted
//               out MSB first, chained back-to-back under one ss-low window,
//               and MISO is captured full duplex into parallel words.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sample_master #(
  parameter int SPI_WIDTH  = 8,
  parameter int CLK_DIV    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic [SPI_WIDTH-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_ss,
  output logic                 o_sclk,
  output logic                 o_mosi,
  input  logic                 i_miso,
  output logic [SPI_WIDTH-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (SPI_WIDTH > 1) ? $clog2(SPI_WIDTH) : 1;

  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(SPI_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TRAIL = 2'd2
  } state_t;

  // Transmit FIFO storage and bookkeeping
  logic [SPI_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  // Shift engine state
  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit;
  logic                 r_trail_half;
  logic [SPI_WIDTH-2:0] r_tx;      // bits still to send after the one on MOSI
  logic [SPI_WIDTH-1:0] r_rx;
  logic                 r_ss;
  logic                 r_sclk;
  logic                 r_mosi;
  logic [SPI_WIDTH-1:0] r_rx_data;
  logic                 r_rx_valid;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_div_end;
  logic                 w_word_end;
  logic [SPI_WIDTH-1:0] w_head;

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // admits a push into a full FIFO.
  assign w_full     = (r_count == C_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_push     = i_valid && !w_full;
  assign w_div_end  = (r_div == C_DIV_LAST);
  assign w_word_end = (r_state == ST_SHIFT) && w_div_end && r_sclk && (r_bit == C_BIT_LAST);
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_word_end);
  assign w_head     = r_mem[r_rd_ptr];

  assign o_ready    = !w_full;
  assign o_ss       = r_ss;
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = !r_ss || !w_empty;

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge i_sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // SPI sequencer: ss/sclk/mosi generation, MISO capture and word hand-off
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_bit        <= '0;
      r_trail_half <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_ss         <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_SHIFT;
            r_ss    <= 1'b0;
            r_sclk  <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
            r_mosi  <= w_head[SPI_WIDTH-1];
            r_tx    <= w_head[SPI_WIDTH-2:0];
          end
        end
        ST_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              // rising sclk: capture MISO
              r_rx <= {r_rx[SPI_WIDTH-2:0], i_miso};
            end else if (r_bit == C_BIT_LAST) begin
              // falling sclk closing the word: publish it, chain or trail
              r_rx_data  <= r_rx;
              r_rx_valid <= 1'b1;
              r_bit      <= '0;
              if (!w_empty) begin
                r_mosi <= w_head[SPI_WIDTH-1];
                r_tx   <= w_head[SPI_WIDTH-2:0];
              end else begin
                r_state      <= ST_TRAIL;
                r_mosi       <= 1'b0;
                r_trail_half <= 1'b0;
              end
            end else begin
              // falling sclk mid-word: present the next bit
              r_bit  <= r_bit + BIT_W'(1);
              r_mosi <= r_tx[SPI_WIDTH-2];
              r_tx   <= r_tx << 1;
            end
          end
        end
        ST_TRAIL: begin
          // two half-periods of hold before releasing ss
          if (!w_div_end) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (r_trail_half) begin
              r_trail_half <= 1'b0;
              r_ss         <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_trail_half <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
